// File: rtl/return_stack_pkg.sv
// Shared definitions for the return stack and the processor control unit.
// Holds the ctrl operation encodings and stack-pointer sizing helper.
package return_stack_pkg;

  // Operation select driven by the control unit; one operation per edge.
  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    PUSH  = 2'b01,
    POP   = 2'b10,
    CLEAR = 2'b11
  } ctrl_e;

  localparam int DEFAULT_N     = 8;
  localparam int DEFAULT_DEPTH = 8;

  // The pointer needs one extra bit so that "full" (sp == DEPTH) is representable.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/return_stack_if.sv
// Control/data bundle between the control unit (master) and the return stack (slave).
interface return_stack_if
  import return_stack_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int SPW = sp_width(DEPTH);

  ctrl_e            ctrl;
  logic [N-1:0]     in;
  logic [N-1:0]     top;
  logic [SPW-1:0]   count;
  logic             empty;
  logic             full;
  logic             err;

  modport master (
    output ctrl, in,
    input  top, count, empty, full, err
  );

  modport slave (
    input  ctrl, in,
    output top, count, empty, full, err
  );

endinterface

// File: rtl/return_stack_mem.sv
// stack_mem: DEPTH x N storage with one falling-edge write port and one
// asynchronous read port. Contents are intentionally not reset.
module stack_mem #(
  parameter int N     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(negedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Hardware return-address stack updated on the falling edge of clk.
// Define RETURN_STACK_ERR_EN to build in the sticky overflow/underflow flag.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  return_stack_if.slave  bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = sp_width(DEPTH);

  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_next;
  logic           is_empty;
  logic           is_full;
  logic           mem_we;
  logic [AW-1:0]  waddr;
  logic [AW-1:0]  raddr;
  logic [N-1:0]   rdata;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == SPW'(DEPTH));

  // Low pointer bits address storage; sp-1 wraps correctly to DEPTH-1 when full.
  assign waddr  = sp[AW-1:0];
  assign raddr  = sp[AW-1:0] - AW'(1);
  assign mem_we = !rst && (bus.ctrl == PUSH) && !is_full;

  always_comb begin
    sp_next = sp;
    case (bus.ctrl)
      HOLD:  sp_next = sp;
      PUSH:  if (!is_full)  sp_next = sp + SPW'(1);
      POP:   if (!is_empty) sp_next = sp - SPW'(1);
      CLEAR: sp_next = '0;
      default: sp_next = sp;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      sp <= '0;
    end else begin
      sp <= sp_next;
    end
  end

  stack_mem #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (bus.in),
    .raddr (raddr),
    .rdata (rdata)
  );

`ifdef RETURN_STACK_ERR_EN
  logic err_q;
  logic err_set;

  assign err_set = ((bus.ctrl == PUSH) && is_full) || ((bus.ctrl == POP) && is_empty);

  always_ff @(negedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.ctrl == CLEAR) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // An empty stack presents 0 so the PC load path never sees stale storage.
  assign bus.top   = is_empty ? '0 : rdata;
  assign bus.count = sp;
  assign bus.empty = is_empty;
  assign bus.full  = is_full;

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: directed scenarios followed by
// randomized operations compared against a queue-based reference stack.
module tb_return_stack;
  import return_stack_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 8;
  localparam int SPW   = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;

  return_stack_if #(.N(N), .DEPTH(DEPTH)) bus ();

  return_stack #(.N(N), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared;
  int n_mismatched;

  logic [N-1:0] ref_stack[$];
  logic         ref_err;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference behaviour: a plain queue, with the error flag following the overflow/underflow rules.
  task automatic model_step(input logic r, input ctrl_e c, input logic [N-1:0] d);
    if (r) begin
      ref_stack.delete();
      ref_err = 1'b0;
    end else begin
      case (c)
        PUSH:  if (ref_stack.size() < DEPTH) ref_stack.push_back(d); else ref_err = 1'b1;
        POP:   if (ref_stack.size() > 0) void'(ref_stack.pop_back()); else ref_err = 1'b1;
        CLEAR: begin ref_stack.delete(); ref_err = 1'b0; end
        default: ;
      endcase
    end
  endtask

  function automatic logic [N-1:0] ref_top();
    if (ref_stack.size() == 0) return '0;
    return ref_stack[ref_stack.size() - 1];
  endfunction

  task automatic check_all(input string tag);
    logic exp_err;
`ifdef RETURN_STACK_ERR_EN
    exp_err = ref_err;
`else
    exp_err = 1'b0;
`endif
    check_output({tag, ".top"},   32'(bus.top),   32'(ref_top()));
    check_output({tag, ".count"}, 32'(bus.count), 32'(ref_stack.size()));
    check_output({tag, ".empty"}, 32'(bus.empty), 32'(ref_stack.size() == 0));
    check_output({tag, ".full"},  32'(bus.full),  32'(ref_stack.size() == DEPTH));
    check_output({tag, ".err"},   32'(bus.err),   32'(exp_err));
  endtask

  // Drive on the rising edge, let the DUT act on the falling edge, sample 1 ns later.
  task automatic apply_stimulus(input string tag, input logic r, input ctrl_e c, input logic [N-1:0] d);
    @(posedge clk);
    rst      = r;
    bus.ctrl = c;
    bus.in   = d;
    @(negedge clk);
    model_step(r, c, d);
    #1;
    check_all(tag);
  endtask

  logic exp_err_flag;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    ref_err      = 1'b0;
    rst          = 1'b1;
    bus.ctrl     = HOLD;
    bus.in       = '0;
`ifdef RETURN_STACK_ERR_EN
    exp_err_flag = 1'b1;
`else
    exp_err_flag = 1'b0;
`endif

    // Reset, then hold.
    apply_stimulus("reset", 1'b1, HOLD, 8'h00);
    apply_stimulus("hold_after_reset", 1'b0, HOLD, 8'h00);
    check_output("reset.count_const", 32'(bus.count), 32'd0);
    check_output("reset.top_const",   32'(bus.top),   32'd0);

    // Push, push, pop.
    apply_stimulus("push10", 1'b0, PUSH, 8'h10);
    check_output("push10.top_const", 32'(bus.top), 32'h10);
    apply_stimulus("push20", 1'b0, PUSH, 8'h20);
    check_output("push20.top_const", 32'(bus.top), 32'h20);
    apply_stimulus("pop1", 1'b0, POP, 8'h00);
    check_output("pop1.top_const", 32'(bus.top), 32'h10);
    check_output("pop1.count_const", 32'(bus.count), 32'd1);
    apply_stimulus("clear1", 1'b0, CLEAR, 8'h00);

    // Fill, then overflow push.
    for (int i = 1; i <= DEPTH; i++) apply_stimulus("fill", 1'b0, PUSH, 8'(i));
    apply_stimulus("overflow", 1'b0, PUSH, 8'hFF);
    check_output("overflow.top_const", 32'(bus.top),  32'h08);
    check_output("overflow.err_const", 32'(bus.err),  32'(exp_err_flag));
    apply_stimulus("hold_full", 1'b0, HOLD, 8'h00);

    // Drain all eight; entries must come back untouched by the rejected push.
    for (int i = 0; i < DEPTH; i++) apply_stimulus("drain", 1'b0, POP, 8'h00);
    check_output("drain.empty_const", 32'(bus.empty), 32'd1);
    apply_stimulus("clear2", 1'b0, CLEAR, 8'h00);
    check_output("clear2.err_const", 32'(bus.err), 32'd0);

    // Underflow then clear.
    apply_stimulus("underflow", 1'b0, POP, 8'h00);
    check_output("underflow.err_const", 32'(bus.err), 32'(exp_err_flag));
    apply_stimulus("hold_err", 1'b0, HOLD, 8'h00);
    apply_stimulus("clear3", 1'b0, CLEAR, 8'h00);

    // Reset overrides a push on the same edge.
    apply_stimulus("pre_rst_push", 1'b0, PUSH, 8'h44);
    apply_stimulus("rst_push", 1'b1, PUSH, 8'h33);
    check_output("rst_push.count_const", 32'(bus.count), 32'd0);
    check_output("rst_push.top_const",   32'(bus.top),   32'd0);

    // Randomized traffic, alternating push-heavy and pop-heavy phases to reach both ends.
    for (int i = 0; i < 400; i++) begin
      int    sel;
      int    push_lim;
      ctrl_e c;
      logic  r;
      sel      = $urandom_range(0, 99);
      push_lim = ((i / 40) % 2 == 0) ? 65 : 25;
      if (sel < push_lim)            c = PUSH;
      else if (sel < push_lim + 30)  c = POP;
      else if (sel < push_lim + 33)  c = HOLD;
      else                           c = CLEAR;
      r = ($urandom_range(0, 99) < 2);
      apply_stimulus("rand", r, c, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter N, default 8, data width of each stored return address.
REQ-002 Parameter DEPTH, default 8, number of entries; a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates occur on the falling edge of clk, matching the processor register file.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ctrl  input  2  operation select: 00 hold, 01 push, 10 pop, 11 clear.
REQ-006 in  input  N  return address to push (normally the incremented PC).
REQ-007 top  output  N  entry at top of stack, feeding the PC load input; 0 when empty.
REQ-008 count  output  clog2(DEPTH)+1  number of valid entries.
REQ-009 empty  output  1  high when count is 0.
REQ-010 full  output  1  high when count equals DEPTH.
REQ-011 err  output  1  sticky overflow/underflow flag (see REQ-030).

Function
REQ-012 The stack pointer sp SHALL be clog2(DEPTH)+1 bits wide; count SHALL equal sp.
REQ-013 hold (00) SHALL leave sp, contents and err unchanged.
REQ-014 push (01) when not full SHALL write in to entry sp and set sp to sp+1 on the same edge.
REQ-015 pop (10) when not empty SHALL set sp to sp-1; the popped value is the top present before the edge.
REQ-016 clear (11) SHALL set sp to 0 and err to 0; entry contents need not be cleared.
REQ-017 top SHALL be a combinational read of entry sp-1 when not empty, and 0 when empty; after a push edge, top SHALL equal the pushed value with no added latency.
REQ-018 empty and full SHALL be combinational decodes of sp.
REQ-019 push while full SHALL leave sp and all contents unchanged (no wrap-around).
REQ-020 pop while empty SHALL leave sp unchanged (no underflow wrap).
REQ-021 Entries below sp SHALL never be modified by any operation except a push that writes at index sp.
REQ-022 ctrl SHALL encode exactly one operation per edge; there is no simultaneous push and pop.

Reset
REQ-023 rst high at a falling edge SHALL set sp to 0 and err to 0, overriding ctrl.
REQ-024 After reset, top SHALL be 0, count 0, empty 1, full 0.
REQ-025 Reset asserted during any operation SHALL abort it; no entry SHALL be written on that edge.
REQ-026 Storage contents SHALL NOT require reset.

Configuration
REQ-027 Macro RETURN_STACK_ERR_EN SHALL compile the error flag in or out.
REQ-028 With RETURN_STACK_ERR_EN defined, err SHALL behave per REQ-030.
REQ-029 Without it, err SHALL be tied to 0 and no error register SHALL exist; REQ-019 and REQ-020 still apply.
REQ-030 err SHALL be set on the edge of a push-while-full or pop-while-empty, and held until rst or clear.

Structure
REQ-031 The ctrl encodings (HOLD, PUSH, POP, CLEAR) SHALL be shared constants in the processor package, also usable by the control unit.
REQ-032 Storage SHALL be a sub-module stack_mem (DEPTH x N, one write port, one asynchronous read port); pointer and flag logic stay in return_stack.

Verification
REQ-033 rst=1 for one edge, then hold -> count=0, empty=1, full=0, top=0, err=0.
REQ-034 push 0x10, push 0x20, pop -> top after each edge is 0x10, 0x20, 0x10; count is 1, 2, 1.
REQ-035 Eight pushes 0x01..0x08, then push 0xFF -> full=1, count=8, top=0x08, err=1 (0 without the macro).
REQ-036 From empty, pop -> count=0, top=0, err=1; then clear -> err=0.
REQ-037 Push 0x33 with rst=1 on the same edge -> count=0, top=0, and no entry is written.
REQ-038 Fill to 8 entries, pop 8 times -> top sequence is 0x07..0x01 then 0, empty=1, no err.
